bp_update_ctrl: RTL and testbench

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_update_ctrl.sv | 123 ++++++++++++
 tb/tb_bp_update_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-resolution update controller: merges two resolution pipes into a
// single in-order predictor update stream through a 4-entry pending FIFO.
module bp_update_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        res0_valid,
    input  logic        res0_taken,
    input  logic [13:0] res0_pc,
    input  logic        res1_valid,
    input  logic        res1_taken,
    input  logic [13:0] res1_pc,
    output logic        res_ready,
    input  logic        upd_en,
    input  logic        flush,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic [13:0] upd_pc,
    output logic [2:0]  q_count,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH = 4;

    logic [14:0] mem_reg [DEPTH];
    logic [1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [2:0]  q_count_reg, q_count_next;
    logic [7:0]  drop_cnt_reg, drop_cnt_next;
    logic        upd_valid_reg;
    logic        upd_taken_reg;
    logic [13:0] upd_pc_reg;

    logic        acc0, acc1;
    logic [14:0] arr0, arr1, first_item, out_item;
    logic [14:0] push_data0, push_data1;
    logic [1:0]  push_cnt, n_drop;
    logic        pop, bypass, emit;
    logic [8:0]  drop_sum;
    logic [DEPTH-1:0] wr_en;
    logic [14:0] wr_data [DEPTH];

    assign res_ready = (q_count_reg <= 3'd2);

    always_comb begin
        acc0       = res0_valid & res_ready & ~flush;
        acc1       = res1_valid & res_ready & ~flush;
        arr0       = {res0_taken, res0_pc};
        arr1       = {res1_taken, res1_pc};
        first_item = acc0 ? arr0 : arr1;

        // Queue contents are always older than anything arriving this cycle.
        pop    = upd_en & (q_count_reg != 3'd0);
        bypass = upd_en & (q_count_reg == 3'd0) & (acc0 | acc1);
        emit   = pop | bypass;

        out_item = pop ? mem_reg[rd_ptr_reg] : first_item;

        push_data0 = bypass ? arr1 : first_item;
        push_data1 = arr1;
        push_cnt   = {1'b0, acc0} + {1'b0, acc1};
        if (bypass) begin
            push_cnt = push_cnt - 2'd1;
        end

        q_count_next = q_count_reg + {1'b0, push_cnt} - {2'b00, pop};

        n_drop = 2'd0;
        if (!flush && !res_ready) begin
            n_drop = {1'b0, res0_valid} + {1'b0, res1_valid};
        end
        drop_sum      = {1'b0, drop_cnt_reg} + {7'b0, n_drop};
        drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Up to two consecutive slots are written per cycle, starting at wr_ptr.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
        assign wr_en[gi] = ~flush &
                           (((push_cnt != 2'd0) && (wr_ptr_reg == 2'(gi))) ||
                            ((push_cnt == 2'd2) && ((wr_ptr_reg + 2'd1) == 2'(gi))));
        assign wr_data[gi] = (wr_ptr_reg == 2'(gi)) ? push_data0 : push_data1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_reg    <= 2'd0;
            wr_ptr_reg    <= 2'd0;
            q_count_reg   <= 3'd0;
            drop_cnt_reg  <= 8'd0;
            upd_valid_reg <= 1'b0;
            upd_taken_reg <= 1'b0;
            upd_pc_reg    <= 14'd0;
        end else if (flush) begin
            rd_ptr_reg    <= 2'd0;
            wr_ptr_reg    <= 2'd0;
            q_count_reg   <= 3'd0;
            upd_valid_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_reg + {1'b0, pop};
            wr_ptr_reg    <= wr_ptr_reg + push_cnt;
            q_count_reg   <= q_count_next;
            drop_cnt_reg  <= drop_cnt_next;
            upd_valid_reg <= emit;
            if (emit) begin
                upd_taken_reg <= out_item[14];
                upd_pc_reg    <= out_item[13:0];
            end
        end
    end

    assign upd_valid = upd_valid_reg;
    assign upd_taken = upd_taken_reg;
    assign upd_pc    = upd_pc_reg;
    assign q_count   = q_count_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a queue model of the pending FIFO
// predicts every update; a negedge monitor checks the update stream.
module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        res0_valid = 1'b0, res0_taken = 1'b0;
    logic [13:0] res0_pc = '0;
    logic        res1_valid = 1'b0, res1_taken = 1'b0;
    logic [13:0] res1_pc = '0;
    logic        res_ready;
    logic        upd_en = 1'b0, flush = 1'b0;
    logic        upd_valid, upd_taken;
    logic [13:0] upd_pc;
    logic [2:0]  q_count;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [14:0] mf[$];
    logic [14:0] exp_q[$];
    int md = 0;

    bp_update_ctrl dut (
        .clk(clk), .rstn(rstn),
        .res0_valid(res0_valid), .res0_taken(res0_taken), .res0_pc(res0_pc),
        .res1_valid(res1_valid), .res1_taken(res1_taken), .res1_pc(res1_pc),
        .res_ready(res_ready), .upd_en(upd_en), .flush(flush),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .q_count(q_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [14:0] e;
            checks = checks + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (upd_valid !== 1'b1 || {upd_taken, upd_pc} !== e) begin
                    errors = errors + 1;
                    $display("FAIL update: got valid=%b taken=%b pc=%h expected valid=1 taken=%b pc=%h",
                             upd_valid, upd_taken, upd_pc, e[14], e[13:0]);
                end else begin
                    $display("update taken=%b pc=%h", upd_taken, upd_pc);
                end
            end else if (upd_valid !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL unexpected_update: got valid=%b pc=%h expected valid=0", upd_valid, upd_pc);
            end
        end
    end

    // Drive one cycle of stimulus and advance the reference model on the edge.
    task automatic cycle(input bit v0, input bit t0, input logic [13:0] p0,
                         input bit v1, input bit t1, input logic [13:0] p1,
                         input bit en, input bit fl);
        res0_valid = v0; res0_taken = t0; res0_pc = p0;
        res1_valid = v1; res1_taken = t1; res1_pc = p1;
        upd_en = en; flush = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            mf.delete();
        end else begin
            if (mf.size() > 2) begin
                md = md + int'(v0) + int'(v1);
                if (md > 255) md = 255;
            end else begin
                if (v0) mf.push_back({t0, p0});
                if (v1) mf.push_back({t1, p1});
            end
            if (en && mf.size() > 0) exp_q.push_back(mf.pop_front());
        end
        res0_valid = 1'b0; res1_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input bit en);
        cycle(0, 0, 14'h0, 0, 0, 14'h0, en, 0);
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        #1;
        checks = checks + 1;
        if (upd_valid !== 1'b0 || upd_taken !== 1'b0 || upd_pc !== 14'h0 ||
            q_count !== 3'd0 || drop_cnt !== 8'd0 || res_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset_state: got v=%b t=%b pc=%h q=%0d d=%0d r=%b expected all 0, ready 1",
                     upd_valid, upd_taken, upd_pc, q_count, drop_cnt, res_ready);
        end
        @(posedge clk);
        #3 rstn = 1'b1;
        mon_en = 1'b1;
        $display("reset released");
    endtask

    task automatic test_bypass;
        cycle(1, 1, 14'h0123, 0, 0, 14'h0, 1, 0);
        checks = checks + 1;
        if (upd_valid !== 1'b1 || upd_taken !== 1'b1 || upd_pc !== 14'h0123 || q_count !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL bypass: got v=%b t=%b pc=%h q=%0d expected v=1 t=1 pc=0123 q=0",
                     upd_valid, upd_taken, upd_pc, q_count);
        end
        idle(1);
        checks = checks + 1;
        if (upd_valid !== 1'b0 || upd_taken !== 1'b1 || upd_pc !== 14'h0123) begin
            errors = errors + 1;
            $display("FAIL hold: got v=%b t=%b pc=%h expected v=0 t=1 pc=0123", upd_valid, upd_taken, upd_pc);
        end
    endtask

    task automatic test_dual;
        cycle(1, 0, 14'h0010, 1, 1, 14'h0020, 1, 0);
        checks = checks + 1;
        if (upd_pc !== 14'h0010 || q_count !== 3'd1) begin
            errors = errors + 1;
            $display("FAIL dual_first: got pc=%h q=%0d expected pc=0010 q=1", upd_pc, q_count);
        end
        idle(1);
        checks = checks + 1;
        if (upd_pc !== 14'h0020 || upd_taken !== 1'b1 || q_count !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL dual_second: got pc=%h t=%b q=%0d expected pc=0020 t=1 q=0", upd_pc, upd_taken, q_count);
        end
        idle(1);
    endtask

    task automatic test_backpressure;
        cycle(1, 1, 14'h0100, 1, 0, 14'h0101, 0, 0);
        cycle(1, 0, 14'h0102, 1, 1, 14'h0103, 0, 0);
        checks = checks + 1;
        if (q_count !== 3'd4 || res_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL bp_full: got q=%0d r=%b expected q=4 r=0", q_count, res_ready);
        end
        cycle(1, 1, 14'h0200, 1, 1, 14'h0201, 0, 0);
        checks = checks + 1;
        if (drop_cnt !== 8'd2 || q_count !== 3'd4) begin
            errors = errors + 1;
            $display("FAIL bp_drop: got d=%0d q=%0d expected d=2 q=4", drop_cnt, q_count);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checks = checks + 1;
            if (upd_valid !== 1'b1 || upd_pc !== 14'h0100 + 14'(i) || q_count !== 3'(3 - i)) begin
                errors = errors + 1;
                $display("FAIL bp_drain%0d: got v=%b pc=%h q=%0d expected v=1 pc=%h q=%0d",
                         i, upd_valid, upd_pc, q_count, 14'h0100 + 14'(i), 3 - i);
            end
        end
        idle(1);
    endtask

    task automatic test_flush;
        cycle(1, 0, 14'h0300, 1, 0, 14'h0301, 0, 0);
        cycle(1, 1, 14'h0302, 0, 0, 14'h0, 0, 0);
        checks = checks + 1;
        if (q_count !== 3'd3) begin
            errors = errors + 1;
            $display("FAIL flush_setup: got q=%0d expected q=3", q_count);
        end
        cycle(1, 1, 14'h0303, 1, 1, 14'h0304, 1, 1);
        checks = checks + 1;
        if (q_count !== 3'd0 || upd_valid !== 1'b0 || drop_cnt !== 8'd2) begin
            errors = errors + 1;
            $display("FAIL flush: got q=%0d v=%b d=%0d expected q=0 v=0 d=2", q_count, upd_valid, drop_cnt);
        end
        repeat (3) idle(1);
        checks = checks + 1;
        if (q_count !== 3'd0 || drop_cnt !== 8'd2) begin
            errors = errors + 1;
            $display("FAIL flush_after: got q=%0d d=%0d expected q=0 d=2", q_count, drop_cnt);
        end
    endtask

    task automatic test_saturation;
        cycle(1, 0, 14'h0400, 1, 0, 14'h0401, 0, 0);
        cycle(1, 0, 14'h0402, 1, 0, 14'h0403, 0, 0);
        for (int i = 0; i < 130; i++) cycle(1, 1, 14'h3FFF, 1, 1, 14'h3FFE, 0, 0);
        checks = checks + 1;
        if (drop_cnt !== 8'd255 || q_count !== 3'd4) begin
            errors = errors + 1;
            $display("FAIL saturate: got d=%0d q=%0d expected d=255 q=4", drop_cnt, q_count);
        end
        cycle(1, 1, 14'h3FFF, 1, 1, 14'h3FFE, 0, 0);
        checks = checks + 1;
        if (drop_cnt !== 8'd255) begin
            errors = errors + 1;
            $display("FAIL saturate_hold: got d=%0d expected d=255", drop_cnt);
        end
        repeat (5) idle(1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
            checks = checks + 1;
            if (q_count !== 3'(mf.size()) || drop_cnt !== 8'(md) || res_ready !== (mf.size() <= 2)) begin
                errors = errors + 1;
                $display("FAIL b2b_%0d: got q=%0d d=%0d r=%b expected q=%0d d=%0d r=%b",
                         i, q_count, drop_cnt, res_ready, mf.size(), md, mf.size() <= 2);
            end
        end
        repeat (5) idle(1);
        checks = checks + 1;
        if (q_count !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL b2b_drain: got q=%0d expected q=0", q_count);
        end
    endtask

    task automatic test_async_reset;
        cycle(1, 1, 14'h0500, 1, 0, 14'h0501, 0, 0);
        cycle(1, 0, 14'h0502, 1, 1, 14'h0503, 0, 0);
        idle(1);
        #3 rstn = 1'b0;
        mf.delete();
        exp_q.delete();
        md = 0;
        #1;
        checks = checks + 1;
        if (upd_valid !== 1'b0 || upd_taken !== 1'b0 || upd_pc !== 14'h0 ||
            q_count !== 3'd0 || drop_cnt !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL async_reset: got v=%b t=%b pc=%h q=%0d d=%0d expected all 0",
                     upd_valid, upd_taken, upd_pc, q_count, drop_cnt);
        end
        @(posedge clk);
        #2 rstn = 1'b1;
        cycle(1, 0, 14'h02AB, 0, 0, 14'h0, 1, 0);
        checks = checks + 1;
        if (upd_valid !== 1'b1 || upd_taken !== 1'b0 || upd_pc !== 14'h02AB || q_count !== 3'd0) begin
            errors = errors + 1;
            $display("FAIL post_reset: got v=%b t=%b pc=%h q=%0d expected v=1 t=0 pc=02ab q=0",
                     upd_valid, upd_taken, upd_pc, q_count);
        end
        repeat (2) idle(1);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual();
        test_backpressure();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
